ms_latch10_send: RTL

- Transmit-side companion for a 10-bit gated transparent-latch interface inside the BCP memory-span (ms) unit.
- Accepts 10-bit words from upstream ms logic through a valid/ready handshake and buffers them in a small FIFO.
- Drives each word onto a registered 10-bit bus (d_out) together with a one-cycle gate strobe (g).
- Data is guaranteed stable for a programmable number of cycles before and after g, so the remote transparent latch (enable = g AND clk) captures cleanly.

---
 rtl/ms_latch10_send_if.sv | 35 +++
 rtl/ms_latch10_send.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/ms_latch10_send_if.sv
// Handshake and latch-bus bundle for ms_latch10_send.
// The d_par wire exists only when MS_SEND_PARITY_EN is defined.
interface ms_latch10_send_if #(
    parameter int DEPTH = 4
);
    localparam int LW = $clog2(DEPTH) + 1;

    logic          in_valid;
    logic          in_ready;
    logic [9:0]    in_data;
    logic          stall;
    logic [9:0]    d_out;
    logic          g;
    logic          busy;
    logic [LW-1:0] level;
`ifdef MS_SEND_PARITY_EN
    logic          d_par;
`endif

    modport master (
        output in_valid, in_data, stall,
        input  in_ready, d_out, g, busy, level
`ifdef MS_SEND_PARITY_EN
        , input d_par
`endif
    );

    modport slave (
        input  in_valid, in_data, stall,
        output in_ready, d_out, g, busy, level
`ifdef MS_SEND_PARITY_EN
        , output d_par
`endif
    );
endinterface

// File: rtl/ms_latch10_send.sv
// Transmit side of a 10-bit gated-latch link: FIFO buffer plus SETUP/GATE/HOLD sequencer.
// Define MS_SEND_PARITY_EN to add the registered odd-parity output d_par.
module ms_latch10_send #(
    parameter int DEPTH     = 4,
    parameter int SETUP_CYC = 1,
    parameter int HOLD_CYC  = 1
) (
    input  logic             clk,
    input  logic             reset,
    ms_latch10_send_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH) + 1;

    localparam logic [LW-1:0] LVL_FULL   = LW'(DEPTH);
    localparam logic [LW-1:0] LVL_ZERO   = LW'(0);
    localparam logic [LW-1:0] LVL_ONE    = LW'(1);
    localparam logic [AW-1:0] PTR_ONE    = AW'(1);
    localparam logic [AW-1:0] PTR_ZERO   = AW'(0);
    localparam logic [2:0]    SETUP_INIT = 3'(SETUP_CYC - 1);
    localparam logic [2:0]    HOLD_INIT  = 3'(HOLD_CYC - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SETUP = 2'd1;
    localparam logic [1:0] S_GATE  = 2'd2;
    localparam logic [1:0] S_HOLD  = 2'd3;

`ifdef MS_SEND_PARITY_EN
    function automatic logic odd_par(input logic [9:0] w);
        return ~^w;
    endfunction
`endif

    logic [9:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q,  level_d;
    logic [1:0]    state_q,  state_d;
    logic [2:0]    cnt_q,    cnt_d;
    logic [9:0]    d_out_q,  d_out_d;
    logic          g_q,      g_d;
    logic          in_ready_q, in_ready_d;
    logic          busy_q,   busy_d;
    logic          push_s;
    logic          pop_s;
    logic          have_word_s;
`ifdef MS_SEND_PARITY_EN
    logic          d_par_q,  d_par_d;
`endif

    // Next-state logic: pop decision, sequencer, pointers and occupancy
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        d_out_d     = d_out_q;
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        level_d     = level_q;
        pop_s       = 1'b0;
        // Full blocks a push even when a pop happens this cycle
        push_s      = bus.in_valid && (level_q != LVL_FULL);
        have_word_s = (level_q != LVL_ZERO) && !bus.stall;
`ifdef MS_SEND_PARITY_EN
        d_par_d     = d_par_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (have_word_s) begin
                    pop_s   = 1'b1;
                    cnt_d   = SETUP_INIT;
                    state_d = S_SETUP;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_SETUP: begin
                if (cnt_q == 3'd0) begin
                    state_d = S_GATE;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            S_GATE: begin
                state_d = S_HOLD;
                cnt_d   = HOLD_INIT;
            end
            S_HOLD: begin
                if (cnt_q != 3'd0) begin
                    cnt_d = cnt_q - 3'd1;
                end else if (have_word_s) begin
                    pop_s   = 1'b1;
                    cnt_d   = SETUP_INIT;
                    state_d = S_SETUP;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = 3'd0;
            end
        endcase

        if (pop_s) begin
            d_out_d  = mem_q[rd_ptr_q];
            rd_ptr_d = rd_ptr_q + PTR_ONE;
`ifdef MS_SEND_PARITY_EN
            d_par_d  = odd_par(mem_q[rd_ptr_q]);
`endif
        end else begin
            rd_ptr_d = rd_ptr_q;
        end

        if (push_s) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end

        case ({push_s, pop_s})
            2'b10:   level_d = level_q + LVL_ONE;
            2'b01:   level_d = level_q - LVL_ONE;
            default: level_d = level_q;
        endcase

        g_d        = (state_d == S_GATE);
        in_ready_d = (level_d != LVL_FULL);
        busy_d     = (state_d != S_IDLE) || (level_d != LVL_ZERO);
    end

    // FIFO storage; contents need no reset since occupancy gates every read
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_q[wr_ptr_q] <= bus.in_data;
        end
    end

    // Control and output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q   <= PTR_ZERO;
            rd_ptr_q   <= PTR_ZERO;
            level_q    <= LVL_ZERO;
            state_q    <= S_IDLE;
            cnt_q      <= 3'd0;
            d_out_q    <= 10'd0;
            g_q        <= 1'b0;
            in_ready_q <= 1'b1;
            busy_q     <= 1'b0;
`ifdef MS_SEND_PARITY_EN
            d_par_q    <= 1'b1;
`endif
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            d_out_q    <= d_out_d;
            g_q        <= g_d;
            in_ready_q <= in_ready_d;
            busy_q     <= busy_d;
`ifdef MS_SEND_PARITY_EN
            d_par_q    <= d_par_d;
`endif
        end
    end

    assign bus.d_out    = d_out_q;
    assign bus.g        = g_q;
    assign bus.in_ready = in_ready_q;
    assign bus.busy     = busy_q;
    assign bus.level    = level_q;
`ifdef MS_SEND_PARITY_EN
    assign bus.d_par    = d_par_q;
`endif
endmodule
